stream_gen: RTL and testbench
=============================

STREAM_GEN -- requirements
Module: stream_gen

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter LWIDTH, default 8: width of the packet-length and gap fields.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  request to send one packet; sampled only in IDLE.
REQ-006 SHALL have port i_len  input  LWIDTH  packet length in beats; 0 = no packet.
REQ-007 SHALL have port i_gap  input  LWIDTH  idle cycles inserted after the last beat.
REQ-008 SHALL have port i_seed  input  DWIDTH  payload value of beat 0.
REQ-009 SHALL have port o_data  output  DWIDTH  stream payload, registered.
REQ-010 SHALL have port o_valid  output  1  stream payload valid, registered.
REQ-011 SHALL have port o_last  output  1  marks the final beat of a packet, registered.
REQ-012 SHALL have port i_ready  input  1  downstream accepts the current beat.
REQ-013 SHALL have port o_busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse at packet completion.
REQ-015 SHALL have port o_count  output  16  running total of transferred beats; wraps modulo 2^16.

Function
REQ-016 SHALL implement states IDLE, SEND and GAP.
REQ-017 SHALL define a transfer as a rising edge where o_valid=1 and i_ready=1.
REQ-018 SHALL, in IDLE with i_start=1 and i_len!=0, latch i_len, i_gap and i_seed.
REQ-019 SHALL, on that IDLE start edge, enter SEND and present beat 0 with o_valid=1 from the next cycle (latency 1).
REQ-020 SHALL ignore i_start when i_len=0: state stays IDLE, o_busy=0, no o_done.
REQ-021 SHALL ignore i_start in SEND and GAP.
REQ-022 SHALL drive beat k with o_data = seed + k modulo 2^DWIDTH, for k = 0..len-1.
REQ-023 SHALL hold o_valid, o_data and o_last stable while o_valid=1 and i_ready=0.
REQ-024 SHALL never deassert o_valid before a transfer, except on reset.
REQ-025 SHALL NOT let o_valid depend combinationally on i_ready.
REQ-026 SHALL present the next beat on the cycle after each non-final transfer, giving one beat per cycle while i_ready=1.
REQ-027 SHALL assert o_last with beat len-1 only; len=1 gives a single beat with o_last=1.
REQ-028 SHALL, on the final transfer, drop o_valid and o_last the following cycle.
REQ-029 SHALL, on the final transfer with gap=0, return to IDLE on that edge.
REQ-030 SHALL, on the final transfer with gap!=0, enter GAP for exactly gap cycles, then go to IDLE.
REQ-031 SHALL pulse o_done for exactly one cycle, the first cycle back in IDLE.
REQ-032 SHALL accept a new i_start in that o_done cycle, giving back-to-back packets with zero bubble when gap=0.
REQ-033 SHALL increment o_count by 1 per transfer, wrapping 0xFFFF to 0x0000.
REQ-034 SHALL use an internal beat counter wide enough for len up to 2^LWIDTH-1.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, set state=IDLE, o_valid=0, o_last=0, o_done=0, o_busy=0, o_data=0, o_count=0 and clear internal counters.
REQ-036 SHALL abandon a packet on reset mid-packet, even with o_valid=1 and the beat unaccepted; reset overrides REQ-024.
REQ-037 SHALL take rst priority over i_start on the same edge.

Verification
REQ-038 SHALL cover basic send: len=4, seed=0x10, gap=0, i_ready=1 -> o_valid 4 consecutive cycles starting 1 cycle after start, data 0x10,0x11,0x12,0x13, o_last with 0x13, o_done next cycle, o_count=4.
REQ-039 SHALL cover backpressure: same packet with i_ready=0 for 3 cycles while 0x12 is presented -> 0x12 and o_valid held 4 cycles, no dropped or duplicated beat, o_count=4.
REQ-040 SHALL cover wrap and single beat: seed=0xFE, len=4 -> 0xFE,0xFF,0x00,0x01; then len=1, seed=0xAA -> one beat 0xAA with o_last=1.
REQ-041 SHALL cover gap and ignored start: len=2, gap=3 -> o_busy high 3 cycles after final transfer; i_start pulsed during GAP is ignored; o_done 1 cycle after GAP ends.
REQ-042 SHALL cover zero length: i_start with i_len=0 -> no o_valid, o_busy=0, no o_done.
REQ-043 SHALL cover reset mid-packet: rst=1 while beat 2 of 8 is stalled -> next cycle o_valid=0, o_busy=0, o_count=0; a fresh packet then starts at its seed.

Source files
------------

// File: rtl/stream_gen.sv
// ---------------------------------------------------------------------------
// stream_gen -- packet stream generator with valid/ready handshake
//
// On a start request in IDLE, latches a packet length, post-packet gap and
// seed, then streams len beats whose payload counts up from the seed
// (modulo 2^DWIDTH). Each beat is held stable until accepted (i_ready).
// The final beat carries o_last. After the final transfer the block idles
// for gap cycles (GAP state) and then returns to IDLE, pulsing o_done on the
// first IDLE cycle. o_count totals all transferred beats (wraps at 2^16).
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   i_start  in   send one packet (sampled in IDLE only)
//   i_len    in   packet length in beats, 0 = no packet
//   i_gap    in   idle cycles inserted after the last beat
//   i_seed   in   payload of beat 0
//   i_ready  in   downstream accepts current beat
//   o_data   out  payload (registered)
//   o_valid  out  payload valid (registered)
//   o_last   out  final beat marker (registered)
//   o_busy   out  state != IDLE
//   o_done   out  one-cycle pulse on first IDLE cycle after a packet
//   o_count  out  running count of transfers, modulo 2^16
// ---------------------------------------------------------------------------
module stream_gen #(
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [LWIDTH-1:0] i_len,
    input  logic [LWIDTH-1:0] i_gap,
    input  logic [DWIDTH-1:0] i_seed,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LWIDTH-1:0] len_q,   len_d;
    logic [LWIDTH-1:0] gap_q,   gap_d;
    logic [LWIDTH-1:0] beat_q,  beat_d;   // index of the beat on o_data
    logic [LWIDTH-1:0] gcnt_q,  gcnt_d;   // gap cycles remaining, incl. current
    logic [DWIDTH-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic              done_q,  done_d;
    logic [15:0]       count_q, count_d;

    logic              xfer;
    logic [LWIDTH-1:0] beat_nxt;
    logic [LWIDTH-1:0] len_m1;

    assign xfer     = valid_q & i_ready;
    assign beat_nxt = beat_q + LWIDTH'(1);
    assign len_m1   = len_q - LWIDTH'(1);

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        beat_d  = beat_q;
        gcnt_d  = gcnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        count_d = xfer ? count_q + 16'd1 : count_q;

        unique case (state_q)
            IDLE: begin
                if (i_start && (i_len != '0)) begin
                    len_d   = i_len;
                    gap_d   = i_gap;
                    beat_d  = '0;
                    data_d  = i_seed;
                    valid_d = 1'b1;
                    last_d  = (i_len == LWIDTH'(1));
                    state_d = SEND;
                end
            end

            SEND: begin
                // Without a transfer everything holds, keeping the beat stable.
                if (xfer) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (gap_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            gcnt_d  = gap_q;
                            state_d = GAP;
                        end
                    end else begin
                        beat_d = beat_nxt;
                        data_d = data_q + DWIDTH'(1);
                        last_d = (beat_nxt == len_m1);
                    end
                end
            end

            GAP: begin
                // gcnt counts down from gap; leaving when it reads 1 yields
                // exactly gap cycles spent here.
                gcnt_d = gcnt_q - LWIDTH'(1);
                if (gcnt_q == LWIDTH'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            beat_q  <= '0;
            gcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            beat_q  <= beat_d;
            gcnt_q  <= gcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_done  = done_q;
    assign o_count = count_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_stream_gen -- directed self-checking bench for stream_gen
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_len;
    logic [7:0]  i_gap;
    logic [7:0]  i_seed;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    stream_gen #(.DWIDTH(8), .LWIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_len   (i_len),
        .i_gap   (i_gap),
        .i_seed  (i_seed),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_count (o_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start in IDLE; returns after the start edge (beat 0 visible).
    task automatic start_pkt(input logic [7:0] len, input logic [7:0] gap,
                             input logic [7:0] seed);
        i_start = 1'b1; i_len = len; i_gap = gap; i_seed = seed;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_len = '0; i_gap = '0; i_seed = '0; i_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({o_valid, o_last, o_busy, o_done, o_data, o_count} !== 28'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%b l=%b b=%b d=%b data=%h cnt=%h expected all zero",
                     o_valid, o_last, o_busy, o_done, o_data, o_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        start_pkt(8'd4, 8'd0, 8'h10);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({o_valid, o_last, o_busy, o_data} !== {1'b1, (k == 3), 1'b1, 8'(8'h10 + k)}) begin
                failures++;
                $display("FAIL basic_beat%0d: got v=%b l=%b b=%b data=%h expected v=1 l=%b b=1 data=%h",
                         k, o_valid, o_last, o_busy, o_data, (k == 3), 8'(8'h10 + k));
            end
            tick();
        end
        exp_count += 16'd4;
        checks++;
        if ({o_valid, o_last, o_busy, o_done, o_count} !== {4'b0001, exp_count}) begin
            failures++;
            $display("FAIL basic_done: got v=%b l=%b b=%b d=%b cnt=%0d expected v=0 l=0 b=0 d=1 cnt=%0d",
                     o_valid, o_last, o_busy, o_done, o_count, exp_count);
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: got done=%b expected 0", o_done);
        end
    endtask

    task automatic test_backpressure();
        start_pkt(8'd4, 8'd0, 8'h10);
        tick();                       // beat 0 accepted
        tick();                       // beat 1 accepted, 0x12 now presented
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) i_ready = 1'b1;
            checks++;
            if ({o_valid, o_last, o_data} !== {2'b10, 8'h12}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b l=%b data=%h expected v=1 l=0 data=12",
                         k, o_valid, o_last, o_data);
            end
            tick();
        end
        checks++;
        if ({o_valid, o_last, o_data} !== {2'b11, 8'h13}) begin
            failures++;
            $display("FAIL bp_last: got v=%b l=%b data=%h expected v=1 l=1 data=13",
                     o_valid, o_last, o_data);
        end
        tick();
        exp_count += 16'd4;
        checks++;
        if ({o_valid, o_done, o_count} !== {2'b01, exp_count}) begin
            failures++;
            $display("FAIL bp_done: got v=%b d=%b cnt=%0d expected v=0 d=1 cnt=%0d",
                     o_valid, o_done, o_count, exp_count);
        end
        tick();
    endtask

    task automatic test_wrap_single();
        logic [7:0] exp_d [4];
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        start_pkt(8'd4, 8'd0, 8'hFE);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({o_valid, o_last, o_data} !== {1'b1, (k == 3), exp_d[k]}) begin
                failures++;
                $display("FAIL wrap_beat%0d: got v=%b l=%b data=%h expected v=1 l=%b data=%h",
                         k, o_valid, o_last, o_data, (k == 3), exp_d[k]);
            end
            tick();
        end
        exp_count += 16'd4;
        start_pkt(8'd1, 8'd0, 8'hAA);   // issued in the o_done cycle
        checks++;
        if ({o_valid, o_last, o_data} !== {2'b11, 8'hAA}) begin
            failures++;
            $display("FAIL single_beat: got v=%b l=%b data=%h expected v=1 l=1 data=aa",
                     o_valid, o_last, o_data);
        end
        tick();
        exp_count += 16'd1;
        checks++;
        if ({o_valid, o_last, o_done, o_count} !== {3'b001, exp_count}) begin
            failures++;
            $display("FAIL single_done: got v=%b l=%b d=%b cnt=%0d expected v=0 l=0 d=1 cnt=%0d",
                     o_valid, o_last, o_done, o_count, exp_count);
        end
        tick();
    endtask

    task automatic test_gap();
        start_pkt(8'd2, 8'd3, 8'h30);
        tick();                       // beat 0
        tick();                       // beat 1 (final) accepted
        exp_count += 16'd2;
        for (int k = 0; k < 3; k++) begin
            // a start request in GAP must be ignored
            i_start = (k == 0); i_len = 8'd5; i_seed = 8'h99;
            checks++;
            if ({o_busy, o_valid, o_done} !== 3'b100) begin
                failures++;
                $display("FAIL gap_cycle%0d: got b=%b v=%b d=%b expected b=1 v=0 d=0",
                         k, o_busy, o_valid, o_done);
            end
            tick();
        end
        i_start = 1'b0;
        checks++;
        if ({o_busy, o_valid, o_done, o_count} !== {3'b001, exp_count}) begin
            failures++;
            $display("FAIL gap_done: got b=%b v=%b d=%b cnt=%0d expected b=0 v=0 d=1 cnt=%0d",
                     o_busy, o_valid, o_done, o_count, exp_count);
        end
        tick();
        checks++;
        if ({o_busy, o_valid, o_done} !== 3'b000) begin
            failures++;
            $display("FAIL gap_start_ignored: got b=%b v=%b d=%b expected 000",
                     o_busy, o_valid, o_done);
        end
    endtask

    task automatic test_zero_len();
        i_start = 1'b1; i_len = 8'd0; i_seed = 8'h55;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({o_busy, o_valid, o_done} !== 3'b000) begin
                failures++;
                $display("FAIL zero_len%0d: got b=%b v=%b d=%b expected 000",
                         k, o_busy, o_valid, o_done);
            end
        end
        i_start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        start_pkt(8'd2, 8'd0, 8'h40);
        tick(); tick();
        exp_count += 16'd2;
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got done=%b expected 1", o_done);
        end
        start_pkt(8'd2, 8'd0, 8'h50);   // accepted in the o_done cycle
        checks++;
        if ({o_valid, o_busy, o_data} !== {2'b11, 8'h50}) begin
            failures++;
            $display("FAIL b2b_second: got v=%b b=%b data=%h expected v=1 b=1 data=50",
                     o_valid, o_busy, o_data);
        end
        tick(); tick();
        exp_count += 16'd2;
        checks++;
        if ({o_done, o_count} !== {1'b1, exp_count}) begin
            failures++;
            $display("FAIL b2b_count: got d=%b cnt=%0d expected d=1 cnt=%0d",
                     o_done, o_count, exp_count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_pkt(8'd8, 8'd0, 8'h60);
        tick(); tick();               // beats 0,1 accepted
        i_ready = 1'b0;
        tick();                       // beat 2 stalled
        checks++;
        if ({o_valid, o_data} !== {1'b1, 8'h62}) begin
            failures++;
            $display("FAIL rstmid_stall: got v=%b data=%h expected v=1 data=62", o_valid, o_data);
        end
        // reset wins over a simultaneous start
        rst = 1'b1; i_start = 1'b1; i_len = 8'd3; i_seed = 8'h11;
        tick();
        rst = 1'b0; i_start = 1'b0;
        exp_count = 16'd0;
        checks++;
        if ({o_valid, o_busy, o_last, o_count} !== {3'b000, 16'd0}) begin
            failures++;
            $display("FAIL rstmid_clear: got v=%b b=%b l=%b cnt=%0d expected v=0 b=0 l=0 cnt=0",
                     o_valid, o_busy, o_last, o_count);
        end
        i_ready = 1'b1;
        start_pkt(8'd2, 8'd0, 8'h70);
        checks++;
        if ({o_valid, o_last, o_data} !== {2'b10, 8'h70}) begin
            failures++;
            $display("FAIL rstmid_fresh: got v=%b l=%b data=%h expected v=1 l=0 data=70",
                     o_valid, o_last, o_data);
        end
        tick(); tick();
        exp_count += 16'd2;
        checks++;
        if ({o_done, o_count} !== {1'b1, exp_count}) begin
            failures++;
            $display("FAIL rstmid_count: got d=%b cnt=%0d expected d=1 cnt=%0d",
                     o_done, o_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_single();
        test_gap();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
